// File: rtl/pwm_dac_scheduler_pkg.sv
// Shared stereo PWM DAC definitions: default widths, scheduler states, channel indices.
package pwm_dac_scheduler_pkg;
   localparam int DW_DEF     = 7;
   localparam int PERIOD_DEF = 128;
   localparam int PCNT_W     = 7;
   localparam int CH_L       = 0;
   localparam int CH_R       = 1;

   typedef enum logic [1:0] {OFF, PRIME, RUN} state_t;
endpackage

// File: rtl/pwm_dac_scheduler_if.sv
// Sample write port (host side) and load bus (PWM counter side) of the DAC scheduler.
interface pwm_dac_scheduler_if
   import pwm_dac_scheduler_pkg::*;
#(
   parameter int DW = DW_DEF
) ();
   logic          wr;
   logic          wr_ch;
   logic [DW-1:0] wr_data;
   logic          req_l;
   logic          req_r;
   logic [DW-1:0] pwm_d_l;
   logic [DW-1:0] pwm_d_r;
   logic          pwm_ldl_l;
   logic          pwm_ldl_r;

   modport master (
      output wr, wr_ch, wr_data,
      input  req_l, req_r, pwm_d_l, pwm_d_r, pwm_ldl_l, pwm_ldl_r
   );

   modport slave (
      input  wr, wr_ch, wr_data,
      output req_l, req_r, pwm_d_l, pwm_d_r, pwm_ldl_l, pwm_ldl_r
   );
endinterface

// File: rtl/pwm_dac_scheduler_fifo2.sv
// Two-entry sample FIFO; head visible combinationally, full flag registered.
// A push on a full FIFO is dropped (o_ovf pulses) unless a pop happens in the same cycle.
module pwm_sample_fifo2 #(
   parameter int DW = 7
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_dat,
   output logic [DW-1:0] o_dat,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_ovf
);
   logic [DW-1:0] r_mem [2];
   logic [1:0]    r_cnt;
   logic          r_full;
   logic          w_do_pop;
   logic          w_do_push;
   logic          w_wr_idx;
   logic [1:0]    w_cnt_nxt;

   assign w_do_pop  = i_pop && (r_cnt != 2'd0);
   assign w_do_push = i_push && ((r_cnt != 2'd2) || w_do_pop);
   // Slot for the new entry after any same-cycle pop has shifted the head out
   assign w_wr_idx  = r_cnt[1] | (r_cnt[0] & ~w_do_pop);

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_do_push && !w_do_pop)
         w_cnt_nxt = r_cnt + 2'd1;
      else if (!w_do_push && w_do_pop)
         w_cnt_nxt = r_cnt - 2'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= 2'd0;
         r_full   <= 1'b0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_full <= (w_cnt_nxt == 2'd2);
         if (w_do_pop)
            r_mem[0] <= r_mem[1];
         if (w_do_push)
            r_mem[w_wr_idx] <= i_dat;
      end
   end

   assign o_dat   = r_mem[0];
   assign o_empty = (r_cnt == 2'd0);
   assign o_full  = r_full;
   assign o_ovf   = i_push && (r_cnt == 2'd2) && !w_do_pop;
endmodule

// File: rtl/pwm_dac_scheduler.sv
// Stereo PWM DAC scheduler: pops one sample per channel each period boundary, load data/strobe at T+1.
// Host flow control via registered req (FIFO not full); empty pops hold data and flag underrun.
module pwm_dac_scheduler
   import pwm_dac_scheduler_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEF,
   parameter int DW     = DW_DEF
) (
   input  logic               MasterClock,
   input  logic               Reset,
   input  logic               xck_en,
   input  logic               enable,
   input  logic               clr_flags,
   output logic [1:0]         underrun,
   output logic [1:0]         overflow,
   pwm_dac_scheduler_if.slave bus
);
   localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PERIOD - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PCNT_W-1:0] r_pcnt;
   logic              w_bnd;
   logic [DW-1:0]     r_d_l;
   logic [DW-1:0]     r_d_r;
   logic              r_ldl;
   logic [1:0]        r_unr;
   logic [1:0]        r_ovf;
   logic [1:0]        w_push;
   logic [1:0]        w_empty;
   logic [1:0]        w_full;
   logic [1:0]        w_ovf;
   logic [DW-1:0]     w_head [2];

   assign w_push[CH_L] = bus.wr && !bus.wr_ch;
   assign w_push[CH_R] = bus.wr && bus.wr_ch;

   for (genvar g = 0; g < 2; g++) begin : g_ch
      pwm_sample_fifo2 #(.DW(DW)) u_fifo (
         .i_clk   (MasterClock),
         .i_rst   (Reset),
         .i_push  (w_push[g]),
         .i_pop   (w_bnd),
         .i_dat   (bus.wr_data),
         .o_dat   (w_head[g]),
         .o_empty (w_empty[g]),
         .o_full  (w_full[g]),
         .o_ovf   (w_ovf[g])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bnd       = 1'b0;
      unique case (r_state)
         OFF:     if (enable) w_state_nxt = PRIME;
         PRIME:   if (w_empty == 2'b00) w_state_nxt = RUN;
         RUN:     w_bnd = enable && xck_en && (r_pcnt == LAST);
         default: w_state_nxt = OFF;
      endcase
      if (!enable)
         w_state_nxt = OFF;
   end

   always_ff @(posedge MasterClock or posedge Reset) begin
      if (Reset) begin
         r_state <= OFF;
         r_pcnt  <= '0;
         r_d_l   <= '0;
         r_d_r   <= '0;
         r_ldl   <= 1'b1;
         r_unr   <= 2'b00;
         r_ovf   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;

         // Tick 0 is the first xck_en seen while already in RUN
         if (r_state != RUN || w_state_nxt != RUN)
            r_pcnt <= '0;
         else if (xck_en)
            r_pcnt <= (r_pcnt == LAST) ? '0 : r_pcnt + PCNT_W'(1);

         if (w_state_nxt == OFF) begin
            r_ldl <= 1'b1;
            r_d_l <= '0;
            r_d_r <= '0;
         end else if (w_bnd) begin
            r_ldl <= 1'b0;
            if (!w_empty[CH_L]) r_d_l <= w_head[CH_L];
            if (!w_empty[CH_R]) r_d_r <= w_head[CH_R];
         end else if (!r_ldl && xck_en) begin
            r_ldl <= 1'b1;
         end

         if (clr_flags) begin
            r_unr <= 2'b00;
            r_ovf <= 2'b00;
         end else begin
            r_unr <= r_unr | (w_empty & {2{w_bnd}});
            r_ovf <= r_ovf | w_ovf;
         end
      end
   end

   assign bus.pwm_d_l   = r_d_l;
   assign bus.pwm_d_r   = r_d_r;
   assign bus.pwm_ldl_l = r_ldl;
   assign bus.pwm_ldl_r = r_ldl;
   assign bus.req_l     = !w_full[CH_L];
   assign bus.req_r     = !w_full[CH_R];
   assign underrun      = r_unr;
   assign overflow      = r_ovf;
endmodule

// File: tb/tb_pwm_dac_scheduler.sv
// Directed bench for pwm_dac_scheduler: write/overflow vector table plus period, strobe and enable sequences.
module tb_pwm_dac_scheduler;
   import pwm_dac_scheduler_pkg::*;

   logic       MasterClock = 1'b0;
   logic       Reset       = 1'b1;
   logic       xck_en      = 1'b0;
   logic       enable      = 1'b0;
   logic       clr_flags   = 1'b0;
   logic [1:0] underrun;
   logic [1:0] overflow;
   bit         xck_auto    = 1'b0;
   int         n_chk       = 0;
   int         n_fail      = 0;
   int         cyc         = 0;
   int         xck_count   = 0;

   pwm_dac_scheduler_if #(.DW(DW_DEF)) bus ();

   pwm_dac_scheduler #(.PERIOD(128), .DW(DW_DEF)) dut (
      .MasterClock (MasterClock),
      .Reset       (Reset),
      .xck_en      (xck_en),
      .enable      (enable),
      .clr_flags   (clr_flags),
      .underrun    (underrun),
      .overflow    (overflow),
      .bus         (bus)
   );

   always #5 MasterClock = ~MasterClock;

   typedef struct {
      logic       wr;
      logic       ch;
      logic [6:0] dat;
      logic       clr;
      logic       req_l;
      logic       req_r;
      logic [1:0] ovf;
   } vec_t;

   vec_t tbl [9];

   // One clock; xck_en pulses on every fourth edge while xck_auto is set
   task automatic tick();
      logic p;
      p = xck_en;
      @(posedge MasterClock);
      #1;
      cyc++;
      if (p) xck_count++;
      xck_en = xck_auto && (cyc % 4 == 0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic write(input logic ch, input logic [6:0] dat);
      bus.wr      = 1'b1;
      bus.wr_ch   = ch;
      bus.wr_data = dat;
      tick();
      bus.wr      = 1'b0;
   endtask

   task automatic run_to_load(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.pwm_ldl_l == 1'b0) begin
            at = xck_count;
            break;
         end
      end
   endtask

   task automatic strobe_width(output int cycles, output int pulses);
      logic p;
      cycles = 0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         p = xck_en;
         tick();
         cycles++;
         if (p) pulses++;
         if (bus.pwm_ldl_l) break;
      end
   endtask

   initial begin
      int base, at, at2, at3, sw_cyc, sw_pul;

      //           wr    ch    dat    clr   req_l req_r ovf
      tbl[0] = '{1'b1, 1'b0, 7'h10, 1'b0, 1'b1, 1'b1, 2'b00};
      tbl[1] = '{1'b1, 1'b0, 7'h20, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[2] = '{1'b1, 1'b0, 7'h30, 1'b0, 1'b0, 1'b1, 2'b01};
      tbl[3] = '{1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 1'b1, 2'b01};
      tbl[4] = '{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 2'b00};
      tbl[5] = '{1'b1, 1'b1, 7'h66, 1'b0, 1'b0, 1'b0, 2'b00};
      tbl[6] = '{1'b1, 1'b1, 7'h77, 1'b0, 1'b0, 1'b0, 2'b10};
      tbl[7] = '{1'b1, 1'b1, 7'h11, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[8] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 2'b00};

      bus.wr      = 1'b0;
      bus.wr_ch   = 1'b0;
      bus.wr_data = '0;
      tick();
      tick();
      chk("rst_ldl", {bus.pwm_ldl_l, bus.pwm_ldl_r}, 2'b11);
      chk("rst_d", {bus.pwm_d_l, bus.pwm_d_r}, 14'h0);
      chk("rst_req", {bus.req_l, bus.req_r}, 2'b11);
      chk("rst_flags", {underrun, overflow}, 4'b0000);
      Reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         bus.wr      = tbl[i].wr;
         bus.wr_ch   = tbl[i].ch;
         bus.wr_data = tbl[i].dat;
         clr_flags   = tbl[i].clr;
         tick();
         chk($sformatf("vec%0d_req", i), {bus.req_l, bus.req_r}, {tbl[i].req_l, tbl[i].req_r});
         chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
      end
      bus.wr    = 1'b0;
      clr_flags = 1'b0;

      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();

      // Prime and first load
      write(1'b0, 7'h10);
      write(1'b1, 7'h55);
      xck_auto = 1'b1;
      enable   = 1'b1;
      tick();
      tick();
      base = xck_count;
      run_to_load(800, at);
      chk("first_load_xck", at - base, 128);
      chk("first_load_d", {bus.pwm_d_l, bus.pwm_d_r}, {7'h10, 7'h55});
      chk("first_load_ldl_r", bus.pwm_ldl_r, 1'b0);
      strobe_width(sw_cyc, sw_pul);
      chk("strobe_xck_low", sw_pul, 1);
      chk("strobe_cycles", sw_cyc, 4);

      // Empty FIFOs at next boundary
      run_to_load(800, at2);
      chk("second_load_xck", at2 - at, 128);
      chk("underrun_both", underrun, 2'b11);
      chk("hold_d", {bus.pwm_d_l, bus.pwm_d_r}, {7'h10, 7'h55});
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("underrun_clr", underrun, 2'b00);
      strobe_width(sw_cyc, sw_pul);

      // Three writes to L without a pop
      write(1'b0, 7'h21);
      chk("req_l_one", bus.req_l, 1'b1);
      write(1'b0, 7'h22);
      chk("req_l_full", bus.req_l, 1'b0);
      write(1'b0, 7'h23);
      chk("ovf_l", overflow, 2'b01);
      run_to_load(800, at3);
      chk("third_load_xck", at3 - at2, 128);
      chk("ovf_pop_d", {bus.pwm_d_l, bus.pwm_d_r}, {7'h21, 7'h55});
      chk("ovf_pop_req_l", bus.req_l, 1'b1);
      chk("underrun_r_only", underrun, 2'b10);

      // Write on a full FIFO in the boundary cycle
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      strobe_width(sw_cyc, sw_pul);
      write(1'b0, 7'h31);
      chk("refill_req_l", bus.req_l, 1'b0);
      for (int i = 0; i < 800 && !(xck_count == at3 + 127 && xck_en); i++)
         tick();
      write(1'b0, 7'h32);
      chk("bnd_wr_ldl", bus.pwm_ldl_l, 1'b0);
      chk("bnd_wr_d_l", bus.pwm_d_l, 7'h22);
      chk("bnd_wr_no_ovf", overflow, 2'b00);
      chk("bnd_wr_req_l", bus.req_l, 1'b0);
      chk("bnd_wr_unr", underrun, 2'b10);

      // Disable mid-strobe, then re-enable
      enable = 1'b0;
      tick();
      chk("dis_ldl", {bus.pwm_ldl_l, bus.pwm_ldl_r}, 2'b11);
      chk("dis_d", {bus.pwm_d_l, bus.pwm_d_r}, 14'h0);
      chk("dis_req", {bus.req_l, bus.req_r}, 2'b01);
      write(1'b0, 7'h5D);
      chk("dis_ovf_l", overflow, 2'b01);
      write(1'b1, 7'h41);
      chk("dis_req_r", bus.req_r, 1'b1);
      enable = 1'b1;
      tick();
      tick();
      base = xck_count;
      run_to_load(800, at);
      chk("reen_load_xck", at - base, 128);
      chk("reen_load_d", {bus.pwm_d_l, bus.pwm_d_r}, {7'h31, 7'h41});

      // Asynchronous reset while the strobe is low
      write(1'b0, 7'h61);
      chk("pre_rst_ldl", bus.pwm_ldl_l, 1'b0);
      chk("pre_rst_req_l", bus.req_l, 1'b0);
      chk("pre_rst_flags", {underrun, overflow}, 4'b1001);
      Reset = 1'b1;
      #1;
      chk("mid_rst_ldl", {bus.pwm_ldl_l, bus.pwm_ldl_r}, 2'b11);
      chk("mid_rst_d", {bus.pwm_d_l, bus.pwm_d_r}, 14'h0);
      chk("mid_rst_req", {bus.req_l, bus.req_r}, 2'b11);
      chk("mid_rst_flags", {underrun, overflow}, 4'b0000);
      tick();
      Reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
